// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic {
        RUN,
        WAIT
    } state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Holds at all-ones instead of wrapping so a long run never reads as a short one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use, taken-branch and memory-wait control for the 5-stage pipeline,
// with a bounded memory freeze and saturating stall/flush statistics.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             use_rs_d,
    input  logic             use_rt_d,
    input  logic             MemRead_e,
    input  logic [4:0]       rt_e,
    input  logic             branch_taken_e,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             nop,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             mem_abort,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t         state, state_nx;
    logic [WCW-1:0] wait_cnt, wait_cnt_nx;
    logic           lu, frz, tmo;
    logic           err_set, stall_inc, flush_inc;

    // Register $zero never carries a real dependency, so it cannot cause a stall.
    assign lu  = MemRead_e && (rt_e != 5'd0) &&
                 ((use_rs_d && (rs_d == rt_e)) || (use_rt_d && (rt_d == rt_e)));
    assign tmo = (state == WAIT) && (wait_cnt == WCW'(MEM_TIMEOUT));
    assign frz = mem_req_m && !mem_ready_m && !tmo;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        nop         = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        mem_abort   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        err_set     = 1'b0;
        state_nx    = state;
        wait_cnt_nx = wait_cnt;

        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            nop        = 1'b1;
        end else begin
            // Freeze beats branch beats load-use; a frozen EX acts on its branch after release.
            if (frz) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
                stall_inc  = 1'b1;
            end else if (branch_taken_e) begin
                ifid_flush = 1'b1;
                nop        = 1'b1;
                flush_inc  = 1'b1;
            end else if (lu) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                nop       = 1'b1;
                stall_inc = 1'b1;
            end

            mem_abort = tmo && !mem_ready_m;

            case (state)
                RUN: begin
                    if (frz) begin
                        state_nx    = WAIT;
                        wait_cnt_nx = WCW'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready_m) begin
                        state_nx    = RUN;
                        wait_cnt_nx = '0;
                    end else if (tmo) begin
                        state_nx    = RUN;
                        wait_cnt_nx = '0;
                        err_set     = 1'b1;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_hazard_ctrl;

    localparam int T    = 4;
    localparam int W    = 4;
    localparam int CMAX = (1 << W) - 1;

    localparam logic [6:0] NORMAL = 7'b1100000;
    localparam logic [6:0] FREEZE = 7'b0000110;
    localparam logic [6:0] BRANCH = 7'b1111000;
    localparam logic [6:0] LUSE   = 7'b0001000;
    localparam logic [6:0] RESET  = 7'b0011000;
    localparam logic [6:0] ABORT  = 7'b1100001;

    logic         clk;
    logic         rst_n;
    logic [4:0]   rs_d, rt_d, rt_e;
    logic         use_rs_d, use_rt_d, MemRead_e, branch_taken_e, mem_req_m, mem_ready_m;
    logic         pc_en, ifid_en, ifid_flush, nop, idex_hold, exmem_hold, mem_abort, mem_err;
    logic [W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: length of the current run of frozen cycles, plus statistics.
    int   m_streak;
    logic m_err;
    int   m_stall, m_flush;

    wire [6:0] obs = {pc_en, ifid_en, ifid_flush, nop, idex_hold, exmem_hold, mem_abort};

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs_d           (rs_d),
        .rt_d           (rt_d),
        .use_rs_d       (use_rs_d),
        .use_rt_d       (use_rt_d),
        .MemRead_e      (MemRead_e),
        .rt_e           (rt_e),
        .branch_taken_e (branch_taken_e),
        .mem_req_m      (mem_req_m),
        .mem_ready_m    (mem_ready_m),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .nop            (nop),
        .idex_hold      (idex_hold),
        .exmem_hold     (exmem_hold),
        .mem_abort      (mem_abort),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input int rs, input int rt, input logic urs, input logic urt,
                          input logic mr, input int rte, input logic br,
                          input logic req, input logic rdy);
        rs_d           = 5'(rs);
        rt_d           = 5'(rt);
        use_rs_d       = urs;
        use_rt_d       = urt;
        MemRead_e      = mr;
        rt_e           = 5'(rte);
        branch_taken_e = br;
        mem_req_m      = req;
        mem_ready_m    = rdy;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic model_lu();
        return MemRead_e && (rt_e != 0) &&
               ((use_rs_d && rs_d == rt_e) || (use_rt_d && rt_d == rt_e));
    endfunction

    function automatic logic [6:0] model_out();
        logic timeout, freeze;
        logic [6:0] v;
        timeout = (m_streak == T);
        freeze  = mem_req_m && !mem_ready_m && !timeout;
        if (!rst_n)              v = RESET;
        else if (freeze)         v = FREEZE;
        else if (branch_taken_e) v = BRANCH;
        else if (model_lu())     v = LUSE;
        else                     v = NORMAL;
        if (rst_n && timeout && !mem_ready_m) v[0] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(8, 8, 1, 1, 1, 8, 1, 1, 0);
        @(negedge clk);
        total++;
        if (obs !== RESET) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, RESET);
        end
        step();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        total++;
        if ({mem_err, stall_cnt, flush_cnt, obs} !== {1'b0, 4'd0, 4'd0, NORMAL}) begin
            bad++;
            $display("FAIL reset_state got err=%b stall=%0d flush=%0d out=%b exp 0/0/0/%b",
                     mem_err, stall_cnt, flush_cnt, obs, NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(8, 0, 1, 0, 1, 8, 0, 0, 0);
        @(negedge clk);
        total++;
        if (obs !== LUSE) begin
            bad++;
            $display("FAIL load_use got=%b exp=%b", obs, LUSE);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if ({obs, stall_cnt} !== {NORMAL, 4'd1}) begin
            bad++;
            $display("FAIL load_use_after got out=%b stall=%0d exp %b 1", obs, stall_cnt, NORMAL);
        end
    endtask

    task automatic test_zero_unused();
        do_reset();
        set_in(0, 0, 1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (obs !== NORMAL) begin
            bad++;
            $display("FAIL zero_reg got=%b exp=%b", obs, NORMAL);
        end
        step();
        set_in(3, 9, 1, 0, 1, 9, 0, 0, 0);
        @(negedge clk);
        total++;
        if (obs !== NORMAL) begin
            bad++;
            $display("FAIL unused_rt got=%b exp=%b", obs, NORMAL);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if (stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL zero_unused_stall got=%0d exp=0", stall_cnt);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_in(8, 0, 1, 0, 1, 8, 1, 0, 0);
        @(negedge clk);
        total++;
        if (obs !== BRANCH) begin
            bad++;
            $display("FAIL branch_lu got=%b exp=%b", obs, BRANCH);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
            bad++;
            $display("FAIL branch_lu_cnt got flush=%0d stall=%0d exp 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
            @(negedge clk);
            total++;
            if (obs !== FREEZE) begin
                bad++;
                $display("FAIL mem_wait_freeze cyc=%0d got=%b exp=%b", i, obs, FREEZE);
            end
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        total++;
        if (obs !== NORMAL) begin
            bad++;
            $display("FAIL mem_wait_release got=%b exp=%b", obs, NORMAL);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if ({stall_cnt, mem_err, flush_cnt} !== {4'd3, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL mem_wait_cnt got stall=%0d err=%b flush=%0d exp 3 0 0",
                     stall_cnt, mem_err, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            total++;
            if (obs !== FREEZE) begin
                bad++;
                $display("FAIL timeout_freeze cyc=%0d got=%b exp=%b", i, obs, FREEZE);
            end
            step();
        end
        @(negedge clk);
        total++;
        if ({obs, mem_err} !== {ABORT, 1'b0}) begin
            bad++;
            $display("FAIL timeout_abort got out=%b err=%b exp %b 0", obs, mem_err, ABORT);
        end
        step();
        idle();
        @(negedge clk);
        total++;
        if ({mem_err, stall_cnt, obs} !== {1'b1, 4'(T), NORMAL}) begin
            bad++;
            $display("FAIL timeout_err got err=%b stall=%0d out=%b exp 1 %0d %b",
                     mem_err, stall_cnt, obs, T, NORMAL);
        end
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        total++;
        if (obs !== RESET) begin
            bad++;
            $display("FAIL timeout_reset_out got=%b exp=%b", obs, RESET);
        end
        step();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        total++;
        if ({mem_err, stall_cnt} !== {1'b0, 4'd0}) begin
            bad++;
            $display("FAIL timeout_reset_clear got err=%b stall=%0d exp 0 0", mem_err, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < T; i++) step();
        mem_ready_m = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== NORMAL) begin
            bad++;
            $display("FAIL ready_at_tmo got=%b exp=%b", obs, NORMAL);
        end
        step();
        mem_ready_m = 1'b0;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            total++;
            if ({obs, mem_err} !== {FREEZE, 1'b0}) begin
                bad++;
                $display("FAIL refreeze cyc=%0d got out=%b err=%b exp %b 0", i, obs, mem_err, FREEZE);
            end
            step();
        end
        @(negedge clk);
        total++;
        if (obs !== ABORT) begin
            bad++;
            $display("FAIL refreeze_abort got=%b exp=%b", obs, ABORT);
        end
        step();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            @(negedge clk);
            total++;
            if (stall_cnt !== 4'((i > CMAX) ? CMAX : i)) begin
                bad++;
                $display("FAIL saturation cyc=%0d got=%0d exp=%0d", i, stall_cnt,
                         (i > CMAX) ? CMAX : i);
            end
        end
        idle();
        step();
    endtask

    task automatic test_random();
        logic [6:0] exp;
        logic       tmo_m, frz_m, lu_m;
        do_reset();
        m_streak = 0;
        m_err    = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        for (int i = 0; i < 600; i++) begin
            rst_n          = ($urandom_range(0, 49) != 0);
            rs_d           = 5'($urandom_range(0, 3));
            rt_d           = 5'($urandom_range(0, 3));
            rt_e           = 5'($urandom_range(0, 3));
            use_rs_d       = 1'($urandom);
            use_rt_d       = 1'($urandom);
            MemRead_e      = 1'($urandom);
            branch_taken_e = ($urandom_range(0, 5) == 0);
            mem_req_m      = (m_streak > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            mem_ready_m    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            exp = model_out();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rand_out cyc=%0d got=%b exp=%b", i, obs, exp);
            end
            total++;
            if ({mem_err, stall_cnt, flush_cnt} !== {m_err, 4'(m_stall), 4'(m_flush)}) begin
                bad++;
                $display("FAIL rand_state cyc=%0d got err=%b stall=%0d flush=%0d exp %b %0d %0d",
                         i, mem_err, stall_cnt, flush_cnt, m_err, m_stall, m_flush);
            end
            tmo_m = (m_streak == T);
            frz_m = mem_req_m && !mem_ready_m && !tmo_m;
            lu_m  = model_lu();
            if (!rst_n) begin
                m_streak = 0;
                m_err    = 1'b0;
                m_stall  = 0;
                m_flush  = 0;
            end else begin
                if (tmo_m && !mem_ready_m) m_err = 1'b1;
                if ((frz_m || (lu_m && !branch_taken_e)) && m_stall < CMAX) m_stall++;
                if (!frz_m && branch_taken_e && m_flush < CMAX) m_flush++;
                m_streak = frz_m ? m_streak + 1 : 0;
            end
            step();
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        test_reset();
        test_load_use();
        test_zero_unused();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
